// File: rtl/lstm_seq_ctrl_if.sv
// ============================================================================
// Module   : lstm_seq_ctrl_if
// Brief    : Control bundle between the layer top / cell and lstm_seq_ctrl.
//            The master side drives start/abort/step count; the slave side
//            (the sequencer) drives busy/done and the per-cycle cell strobes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface lstm_seq_ctrl_if #(
    parameter int STEP_W = 8,
    parameter int ADDR_W = 10
);
    logic              i_start;
    logic              i_abort;
    logic [STEP_W-1:0] i_steps;
    logic              o_busy;
    logic              o_done;
    logic              o_clr;
    logic              o_acc_x;
    logic              o_acc_h;
    logic [ADDR_W-1:0] o_k;
    logic [ADDR_W-1:0] o_x_addr;
    logic              o_wb;
    logic [STEP_W-1:0] o_t;

    // Requester side: layer top (or a testbench)
    modport master (
        output i_start, i_abort, i_steps,
        input  o_busy, o_done, o_clr, o_acc_x, o_acc_h, o_k, o_x_addr, o_wb, o_t
    );

    // Sequencer side
    modport slave (
        input  i_start, i_abort, i_steps,
        output o_busy, o_done, o_clr, o_acc_x, o_acc_h, o_k, o_x_addr, o_wb, o_t
    );
endinterface

`default_nettype wire

// File: rtl/lstm_seq_ctrl.sv
// ============================================================================
// Module   : lstm_seq_ctrl
// Brief    : Timestep sequencer for one lstm_cell. Per timestep: clear the
//            accumulators, stream max(X_LEN,H_LEN) accumulate cycles, wait
//            LAT cycles for the activation pipeline, then strobe write-back.
//            Pulses done after the last timestep; abort drops to idle at once.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lstm_seq_ctrl #(
    parameter int X_LEN  = 4,
    parameter int H_LEN  = 4,
    parameter int LAT    = 3,
    parameter int STEP_W = 8,
    parameter int ADDR_W = 10
) (
    input  wire logic          clk,
    input  wire logic          rst,   // synchronous, active-low
    lstm_seq_ctrl_if.slave     bus
);

    // Number of accumulate cycles per timestep
    localparam int c_N      = (X_LEN > H_LEN) ? X_LEN : H_LEN;
    localparam int c_WCNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [ADDR_W-1:0]   c_K_LAST  = ADDR_W'(c_N - 1);
    localparam logic [ADDR_W-1:0]   c_X_LEN_A = ADDR_W'(X_LEN);
    localparam logic [ADDR_W-1:0]   c_H_LEN_A = ADDR_W'(H_LEN);
    localparam logic [c_WCNT_W-1:0] c_W_LAST  = c_WCNT_W'(LAT - 1);

    // State encoding
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_CLR  = 3'd1;
    localparam logic [2:0] c_ST_ACC  = 3'd2;
    localparam logic [2:0] c_ST_WAIT = 3'd3;
    localparam logic [2:0] c_ST_WB   = 3'd4;
    localparam logic [2:0] c_ST_DONE = 3'd5;

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_k;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [STEP_W-1:0]   r_t;
    logic [STEP_W-1:0]   r_steps;
    logic [ADDR_W-1:0]   r_base;    // t*X_LEN kept incrementally, wraps mod 2^ADDR_W

    logic [2:0]          w_nxt_state;
    logic [ADDR_W-1:0]   w_nxt_k;
    logic [c_WCNT_W-1:0] w_nxt_wcnt;
    logic [STEP_W-1:0]   w_nxt_t;
    logic [STEP_W-1:0]   w_nxt_steps;
    logic [ADDR_W-1:0]   w_nxt_base;

    logic                r_busy, r_done, r_clr, r_acc_x, r_acc_h, r_wb;
    logic [ADDR_W-1:0]   r_k_out, r_x_addr;
    logic [STEP_W-1:0]   r_t_out;

    // Next-state and counter logic; abort overrides every other transition
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_k     = r_k;
        w_nxt_wcnt  = r_wcnt;
        w_nxt_t     = r_t;
        w_nxt_steps = r_steps;
        w_nxt_base  = r_base;
        if (r_state != c_ST_IDLE && bus.i_abort) begin
            w_nxt_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.i_start && !bus.i_abort) begin
                        w_nxt_steps = bus.i_steps;
                        w_nxt_t     = '0;
                        w_nxt_base  = '0;
                        w_nxt_state = (bus.i_steps != '0) ? c_ST_CLR : c_ST_DONE;
                    end
                end
                c_ST_CLR: begin
                    w_nxt_k     = '0;
                    w_nxt_state = c_ST_ACC;
                end
                c_ST_ACC: begin
                    if (r_k == c_K_LAST) begin
                        w_nxt_wcnt  = '0;
                        w_nxt_state = c_ST_WAIT;
                    end else begin
                        w_nxt_k = r_k + 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    if (r_wcnt == c_W_LAST) begin
                        w_nxt_state = c_ST_WB;
                    end else begin
                        w_nxt_wcnt = r_wcnt + 1'b1;
                    end
                end
                c_ST_WB: begin
                    if (r_t == r_steps - STEP_W'(1)) begin
                        w_nxt_state = c_ST_DONE;
                    end else begin
                        w_nxt_t     = r_t + 1'b1;
                        w_nxt_base  = r_base + c_X_LEN_A;
                        w_nxt_state = c_ST_CLR;
                    end
                end
                c_ST_DONE: begin
                    w_nxt_state = c_ST_IDLE;
                end
                default: begin
                    w_nxt_state = c_ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= c_ST_IDLE;
            r_k      <= '0;
            r_wcnt   <= '0;
            r_t      <= '0;
            r_steps  <= '0;
            r_base   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_clr    <= 1'b0;
            r_acc_x  <= 1'b0;
            r_acc_h  <= 1'b0;
            r_wb     <= 1'b0;
            r_k_out  <= '0;
            r_x_addr <= '0;
            r_t_out  <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_k      <= w_nxt_k;
            r_wcnt   <= w_nxt_wcnt;
            r_t      <= w_nxt_t;
            r_steps  <= w_nxt_steps;
            r_base   <= w_nxt_base;
            r_busy   <= (w_nxt_state != c_ST_IDLE);
            r_done   <= (w_nxt_state == c_ST_DONE);
            r_clr    <= (w_nxt_state == c_ST_CLR);
            r_acc_x  <= (w_nxt_state == c_ST_ACC) && (w_nxt_k < c_X_LEN_A);
            r_acc_h  <= (w_nxt_state == c_ST_ACC) && (w_nxt_k < c_H_LEN_A);
            r_wb     <= (w_nxt_state == c_ST_WB);
            r_k_out  <= w_nxt_k;
            r_x_addr <= w_nxt_base + w_nxt_k;
            r_t_out  <= w_nxt_t;
        end
    end

    assign bus.o_busy   = r_busy;
    assign bus.o_done   = r_done;
    assign bus.o_clr    = r_clr;
    assign bus.o_acc_x  = r_acc_x;
    assign bus.o_acc_h  = r_acc_h;
    assign bus.o_wb     = r_wb;
    assign bus.o_k      = r_k_out;
    assign bus.o_x_addr = r_x_addr;
    assign bus.o_t      = r_t_out;

endmodule

`default_nettype wire

// File: tb/tb_lstm_seq_ctrl.sv
// ============================================================================
// Module   : tb_lstm_seq_ctrl
// Brief    : Self-checking bench for lstm_seq_ctrl. Two instances:
//            A (X_LEN=2,H_LEN=3,LAT=3) and B (X_LEN=5,H_LEN=2,LAT=3).
//            Expected outputs come from a per-cycle timing model of the
//            timestep schedule (clear, accumulate, wait, write-back, done).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lstm_seq_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    lstm_seq_ctrl_if #(.STEP_W(8), .ADDR_W(10)) ifa ();
    lstm_seq_ctrl_if #(.STEP_W(8), .ADDR_W(10)) ifb ();

    lstm_seq_ctrl #(.X_LEN(2), .H_LEN(3), .LAT(3), .STEP_W(8), .ADDR_W(10)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    lstm_seq_ctrl #(.X_LEN(5), .H_LEN(2), .LAT(3), .STEP_W(8), .ADDR_W(10)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_in(input int inst, input logic st, input logic ab, input logic [7:0] s);
        if (inst == 0) begin
            ifa.i_start = st; ifa.i_abort = ab; ifa.i_steps = s;
        end else begin
            ifb.i_start = st; ifb.i_abort = ab; ifb.i_steps = s;
        end
    endtask

    // Strobe vector order: {busy, clr, acc_x, acc_h, wb, done}
    task automatic get_out(input int inst, output logic [5:0] st, output logic [9:0] k,
                           output logic [9:0] xa, output logic [7:0] t);
        if (inst == 0) begin
            st = {ifa.o_busy, ifa.o_clr, ifa.o_acc_x, ifa.o_acc_h, ifa.o_wb, ifa.o_done};
            k = ifa.o_k; xa = ifa.o_x_addr; t = ifa.o_t;
        end else begin
            st = {ifb.o_busy, ifb.o_clr, ifb.o_acc_x, ifb.o_acc_h, ifb.o_wb, ifb.o_done};
            k = ifb.o_k; xa = ifb.o_x_addr; t = ifb.o_t;
        end
    endtask

    // One start of S steps on instance inst; optional abort / reset at a cycle
    // (0 = none) and start/steps noise while the sequence is running.
    task automatic run_seq(input string name, input int inst, input int s_steps,
                           input int abort_at, input int rst_at, input bit noise);
        int xl, hl, lat, n, p, end_c, cut, last;
        logic [5:0] st, est;
        logic [9:0] k, xa, ek, exa;
        logic [7:0] t, et;
        bit chk_f;
        xl  = (inst == 0) ? 2 : 5;
        hl  = (inst == 0) ? 3 : 2;
        lat = 3;
        n   = (xl > hl) ? xl : hl;
        p   = n + lat + 2;
        end_c = (s_steps == 0) ? 1 : s_steps * p + 1;
        cut = end_c;
        if (abort_at > 0 && abort_at < cut) cut = abort_at;
        if (rst_at > 0 && rst_at < cut) cut = rst_at;
        last = cut + 5;

        @(negedge clk);
        set_in(inst, 1'b1, 1'b0, 8'(s_steps));
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            get_out(inst, st, k, xa, t);
            est = '0; ek = '0; exa = '0; et = '0; chk_f = 1'b0;
            if (rst_at > 0 && c > rst_at) begin
                chk_f = 1'b1;
            end else if (abort_at > 0 && c > abort_at) begin
                chk_f = 1'b0;
            end else if (c < end_c) begin
                int s, off, kk;
                s   = (c - 1) / p;
                off = (c - 1) % p;
                est[5] = 1'b1;
                est[4] = (off == 0);
                est[3] = (off >= 1) && (off <= n) && (off - 1 < xl);
                est[2] = (off >= 1) && (off <= n) && (off - 1 < hl);
                est[1] = (off == p - 1);
                et = 8'(s);
                if (off >= 1) begin
                    kk  = (off - 1 < n - 1) ? off - 1 : n - 1;
                    ek  = 10'(kk);
                    exa = 10'(s * xl + kk);
                    chk_f = 1'b1;
                end
            end else if (c == end_c) begin
                est = 6'b100001;
            end
            checks++;
            if (st !== est) begin
                failures++;
                $display("FAIL %s strobes cycle=%0d got=%b exp=%b", name, c, st, est);
            end
            if (chk_f) begin
                checks++;
                if ({k, xa, t} !== {ek, exa, et}) begin
                    failures++;
                    $display("FAIL %s fields cycle=%0d got k=%0d xa=%0d t=%0d exp k=%0d xa=%0d t=%0d",
                             name, c, k, xa, t, ek, exa, et);
                end
            end
            // Drive for the cycle that ends at the next edge
            rst = (c == rst_at) ? 1'b0 : 1'b1;
            if (noise && c <= cut)
                set_in(inst, 1'($urandom_range(0, 1)), (c == abort_at), 8'($urandom_range(0, 255)));
            else
                set_in(inst, 1'b0, (c == abort_at), 8'(s_steps));
        end
        set_in(inst, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_reset();
        logic [5:0] st;
        logic [9:0] k, xa;
        logic [7:0] t;
        rst = 1'b0;
        set_in(0, 1'b1, 1'b0, 8'd3);
        set_in(1, 1'b1, 1'b0, 8'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 8'd0);
        set_in(1, 1'b0, 1'b0, 8'd0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            get_out(i, st, k, xa, t);
            checks++;
            if ({st, k, xa, t} !== '0) begin
                failures++;
                $display("FAIL reset inst=%0d got st=%b k=%0d xa=%0d t=%0d exp all 0", i, st, k, xa, t);
            end
        end
    endtask

    task automatic test_single_step();   run_seq("single_step", 0, 1, 0, 0, 1'b0); endtask
    task automatic test_two_steps();     run_seq("two_steps",   0, 2, 0, 0, 1'b0); endtask
    task automatic test_zero_steps();    run_seq("zero_steps",  0, 0, 0, 0, 1'b0); endtask

    task automatic test_abort();
        logic [5:0] st;
        logic [9:0] k, xa;
        logic [7:0] t;
        // Abort during the second timestep's accumulate phase (period 8)
        run_seq("abort", 0, 3, 11, 0, 1'b0);
        run_seq("restart", 0, 1, 0, 0, 1'b0);
        // Start together with abort in idle must be ignored
        @(negedge clk);
        set_in(0, 1'b1, 1'b1, 8'd2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_in(0, 1'b0, 1'b0, 8'd0);
            get_out(0, st, k, xa, t);
            checks++;
            if (st !== 6'b0) begin
                failures++;
                $display("FAIL abort_idle_start cycle=%0d got=%b exp=%b", c, st, 6'b0);
            end
        end
    endtask

    task automatic test_noise_reset();
        // Start noise while busy, reset asserted in the first WAIT phase
        run_seq("noise_reset", 0, 3, 0, 6, 1'b1);
    endtask

    task automatic test_override();      run_seq("override", 1, 1, 0, 0, 1'b0); endtask

    task automatic test_back_to_back();
        run_seq("b2b_a", 0, 2, 0, 0, 1'b1);
        run_seq("b2b_b", 0, 1, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int inst, s, ab, p, end_c;
            inst  = $urandom_range(0, 1);
            s     = $urandom_range(0, 4);
            p     = (inst == 0) ? 8 : 10;
            end_c = (s == 0) ? 1 : s * p + 1;
            ab    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, end_c) : 0;
            run_seq("random", inst, s, ab, 0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        set_in(0, 1'b0, 1'b0, 8'd0);
        set_in(1, 1'b0, 1'b0, 8'd0);
        test_reset();
        test_single_step();
        test_two_steps();
        test_zero_steps();
        test_abort();
        test_noise_reset();
        test_override();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
